// File: rtl/uart_frame_parser_pkg.sv
// Shared definitions for the UART status-frame parser: frame constants,
// FSM state encoding and the error-code enumeration.
package uart_frame_pkg;

  localparam logic [7:0] FRAME_HEADER  = 8'hAD;
  localparam int         FRAME_LEN     = 12;
  localparam logic [7:0] FRAME_TERM    = 8'h0A;
  localparam logic [3:0] PAYLOAD_LAST  = 4'd8;   // index of the 9th payload char

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_TERM    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_LEN     = 2'd0,
    ERR_HEX     = 2'd1,
    ERR_TERM    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_t;

endpackage

// File: rtl/uart_frame_parser_if.sv
// Byte-stream input and decoded-frame output bundle of the parser.
// Handshake: a byte transfers on a clock edge where rx_data_valid and
// rx_data_ready are both high; rx_data must be stable while rx_data_valid
// is high. frame_valid / frame_err are single-cycle pulses with no ready.
interface uart_frame_parser_if;
  logic [7:0]  rx_data;
  logic        rx_data_valid;
  logic        rx_data_ready;
  logic [7:0]  mod_type;
  logic [15:0] demod_fre;
  logic [7:0]  mod_depth;
  logic [7:0]  delta_freq;
  logic        frame_valid;
  logic        frame_err;
  logic [1:0]  err_code;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  // Parser side
  modport slave (
    input  rx_data, rx_data_valid,
    output rx_data_ready, mod_type, demod_fre, mod_depth, delta_freq,
           frame_valid, frame_err, err_code, frame_cnt, err_cnt
  );

  // Byte source / result consumer side
  modport master (
    output rx_data, rx_data_valid,
    input  rx_data_ready, mod_type, demod_fre, mod_depth, delta_freq,
           frame_valid, frame_err, err_code, frame_cnt, err_cnt
  );
endinterface

// File: rtl/uart_frame_parser_hex_nibble_dec.sv
// ASCII hex character to nibble decoder ('0'-'9', 'A'-'F', 'a'-'f').
module uart_hex_nibble_dec (
  input  logic [7:0] char_i,
  output logic [3:0] nibble_o,
  output logic       is_hex_o
);

  // Digits map straight through their low nibble; letters 'A'/'a' have
  // low nibble 1, so adding 9 yields 10..15.
  always_comb begin
    nibble_o = 4'd0;
    is_hex_o = 1'b0;
    if (char_i >= 8'h30 && char_i <= 8'h39) begin
      nibble_o = char_i[3:0];
      is_hex_o = 1'b1;
    end else if ((char_i >= 8'h41 && char_i <= 8'h46) ||
                 (char_i >= 8'h61 && char_i <= 8'h66)) begin
      nibble_o = char_i[3:0] + 4'd9;
      is_hex_o = 1'b1;
    end
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Demodulator status-frame parser sitting behind a uart_rx.
// Frame: HEADER, length (12), 9 ASCII-hex chars, '\n'.
// Optional inter-byte timeout enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_frame_parser #(
  parameter int         CLK_FRE    = 50,
  parameter logic [7:0] HEADER     = uart_frame_pkg::FRAME_HEADER,
  parameter int         FRAME_LEN  = uart_frame_pkg::FRAME_LEN,
  parameter int         TIMEOUT_US = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_frame_parser_if.slave     bus,
  output uart_frame_pkg::state_t dbg_state_o
);
  import uart_frame_pkg::*;

  localparam longint TMO_CYCLES = longint'(CLK_FRE) * longint'(TIMEOUT_US);

  // The timeout limit must fit the 32-bit counter and be non-zero.
  if (TMO_CYCLES < 1 || TMO_CYCLES > 64'sd4294967295) begin : g_bad_timeout
    $error("uart_frame_parser: CLK_FRE*TIMEOUT_US out of range");
  end

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [35:0] shadow_q, shadow_d;

  logic        rdy_q;
  logic [3:0]  mod_q;
  logic [15:0] fre_q;
  logic [7:0]  depth_q;
  logic [7:0]  delta_q;
  logic        fvalid_q, ferr_q;
  err_code_t   err_code_q, err_sel;
  logic [15:0] frame_cnt_q, err_cnt_q;

  logic        accept, commit, err, timeout_hit;
  logic [3:0]  nibble;
  logic        is_hex;

  assign accept = bus.rx_data_valid && rdy_q;

  uart_hex_nibble_dec u_hex (
    .char_i   (bus.rx_data),
    .nibble_o (nibble),
    .is_hex_o (is_hex)
  );

`ifdef UART_FRAME_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TMO_CYCLES - 1);
  logic [31:0] tmo_q;

  // Idle-cycle counter: runs while a frame is open, cleared by any byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  tmo_q <= '0;
    else if (state_q == ST_HUNT || accept || timeout_hit) tmo_q <= '0;
    else                                      tmo_q <= tmo_q + 32'd1;
  end

  assign timeout_hit = (state_q != ST_HUNT) && (tmo_q == TMO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // FSM state, payload index and shadow register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_HUNT;
      idx_q    <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
    end
  end

  // Next-state decode; a timeout takes priority over a same-cycle byte.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    commit   = 1'b0;
    err      = 1'b0;
    err_sel  = ERR_LEN;
    if (timeout_hit) begin
      state_d  = ST_HUNT;
      idx_d    = '0;
      shadow_d = '0;
      err      = 1'b1;
      err_sel  = ERR_TIMEOUT;
    end else if (accept) begin
      case (state_q)
        ST_HUNT: begin
          if (bus.rx_data == HEADER) state_d = ST_LEN;
        end
        ST_LEN: begin
          if (bus.rx_data == 8'(FRAME_LEN)) begin
            state_d  = ST_PAYLOAD;
            idx_d    = '0;
            shadow_d = '0;
          end else if (bus.rx_data != HEADER) begin
            state_d = ST_HUNT;
            err     = 1'b1;
            err_sel = ERR_LEN;
          end
        end
        ST_PAYLOAD: begin
          if (is_hex) begin
            shadow_d = {shadow_q[31:0], nibble};
            if (idx_q == PAYLOAD_LAST) state_d = ST_TERM;
            else                       idx_d   = idx_q + 4'd1;
          end else begin
            state_d = (bus.rx_data == HEADER) ? ST_LEN : ST_HUNT;
            err     = 1'b1;
            err_sel = ERR_HEX;
          end
        end
        ST_TERM: begin
          if (bus.rx_data == FRAME_TERM) begin
            state_d = ST_HUNT;
            commit  = 1'b1;
          end else begin
            state_d = (bus.rx_data == HEADER) ? ST_LEN : ST_HUNT;
            err     = 1'b1;
            err_sel = ERR_TERM;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  // Output registers: fields load only on commit, counters and pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q       <= 1'b0;
      mod_q       <= '0;
      fre_q       <= '0;
      depth_q     <= '0;
      delta_q     <= '0;
      fvalid_q    <= 1'b0;
      ferr_q      <= 1'b0;
      err_code_q  <= ERR_LEN;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      rdy_q    <= 1'b1;
      fvalid_q <= commit;
      ferr_q   <= err;
      if (commit) begin
        mod_q       <= shadow_q[35:32];
        fre_q       <= shadow_q[31:16];
        depth_q     <= shadow_q[15:8];
        delta_q     <= shadow_q[7:0];
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if (err) begin
        err_code_q <= err_sel;
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end

  assign bus.rx_data_ready = rdy_q;
  assign bus.mod_type      = {4'h0, mod_q};
  assign bus.demod_fre     = fre_q;
  assign bus.mod_depth     = depth_q;
  assign bus.delta_freq    = delta_q;
  assign bus.frame_valid   = fvalid_q;
  assign bus.frame_err     = ferr_q;
  assign bus.err_code      = err_code_q;
  assign bus.frame_cnt     = frame_cnt_q;
  assign bus.err_cnt       = err_cnt_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser with an expected-event queue.
// Timeout scenario expectations follow UART_FRAME_TIMEOUT_EN.
module tb_uart_frame_parser;
  import uart_frame_pkg::*;

  localparam int W = 76;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_frame_parser_if bus ();
  state_t dbg_state;

  uart_frame_parser #(
    .CLK_FRE    (50),
    .HEADER     (8'hAD),
    .FRAME_LEN  (12),
    .TIMEOUT_US (10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ev(input logic v, input logic e,
                                      input logic [7:0] m, input logic [15:0] f,
                                      input logic [7:0] d, input logic [7:0] dl,
                                      input logic [1:0] c, input logic [15:0] fc,
                                      input logic [15:0] ec);
    return {v, e, m, f, d, dl, c, fc, ec};
  endfunction

  function automatic logic [W-1:0] observed();
    return {bus.frame_valid, bus.frame_err, bus.mod_type, bus.demod_fre,
            bus.mod_depth, bus.delta_freq, bus.err_code, bus.frame_cnt, bus.err_cnt};
  endfunction

  // Monitor: every output pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && (bus.frame_valid === 1'b1 || bus.frame_err === 1'b1)) begin
      if (exp_q.size() == 0) chk("unexpected_event", 80'(observed()), 80'(0));
      else                   chk("event", 80'(observed()), 80'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    int gap;
    int waited;
    gap = $urandom_range(0, 2);
    repeat (gap) @(negedge clk);
    bus.rx_data       = b;
    bus.rx_data_valid = 1'b1;
    waited = 0;
    while (bus.rx_data_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (bus.rx_data_ready !== 1'b1) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ready_wait: rx_data_ready=%b expected 1", bus.rx_data_ready);
    end
    @(negedge clk);
    bus.rx_data_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic send_frame(input string payload, input logic [7:0] term);
    send_byte(8'hAD);
    send_byte(8'h0C);
    send_str(payload);
    send_byte(term);
  endtask

  task automatic drain(input string name);
    repeat (5) @(negedge clk);
    chk(name, 80'(exp_q.size()), 80'(0));
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_ready"}, 80'(bus.rx_data_ready), 80'(0));
    chk({name, "_fields"}, 80'({bus.mod_type, bus.demod_fre, bus.mod_depth, bus.delta_freq}), 80'(0));
    chk({name, "_pulses"}, 80'({bus.frame_valid, bus.frame_err, bus.err_code}), 80'(0));
    chk({name, "_counts"}, 80'({bus.frame_cnt, bus.err_cnt}), 80'(0));
    chk({name, "_state"}, 80'(dbg_state), 80'(ST_HUNT));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst               = 1'b1;
    bus.rx_data       = 8'h00;
    bus.rx_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("ready_after_reset", 80'(bus.rx_data_ready), 80'(1));

    // Basic frame, uppercase
    exp_q.push_back(ev(1, 0, 8'h03, 16'h1A2F, 8'h40, 8'h0C, 2'd0, 16'd1, 16'd0));
    send_frame("31A2F400C", 8'h0A);

    // Same frame, lowercase hex
    exp_q.push_back(ev(1, 0, 8'h03, 16'h1A2F, 8'h40, 8'h0C, 2'd0, 16'd2, 16'd0));
    send_frame("31a2f400c", 8'h0A);

    // Bad length; trailing bytes are dropped silently in HUNT
    exp_q.push_back(ev(0, 1, 8'h03, 16'h1A2F, 8'h40, 8'h0C, 2'd0, 16'd2, 16'd1));
    send_byte(8'hAD);
    send_byte(8'h0B);
    send_str("31A2F");
    send_byte(8'h0A);

    // 'G' at payload index 3, then a good frame
    exp_q.push_back(ev(0, 1, 8'h03, 16'h1A2F, 8'h40, 8'h0C, 2'd1, 16'd2, 16'd2));
    send_byte(8'hAD);
    send_byte(8'h0C);
    send_str("31AG");
    exp_q.push_back(ev(1, 0, 8'h05, 16'hBEEF, 8'h12, 8'h34, 2'd1, 16'd3, 16'd2));
    send_frame("5BEEF1234", 8'h0A);

    // CR instead of LF
    exp_q.push_back(ev(0, 1, 8'h05, 16'hBEEF, 8'h12, 8'h34, 2'd2, 16'd3, 16'd3));
    send_frame("700010203", 8'h0D);

    // Header inside payload, then full frame (its own header resyncs in LEN)
    exp_q.push_back(ev(0, 1, 8'h05, 16'hBEEF, 8'h12, 8'h34, 2'd1, 16'd3, 16'd4));
    send_byte(8'hAD);
    send_byte(8'h0C);
    send_str("12");
    send_byte(8'hAD);
    exp_q.push_back(ev(1, 0, 8'h09, 16'hFFFF, 8'h80, 8'h01, 2'd1, 16'd4, 16'd4));
    send_frame("9FFFF8001", 8'h0A);

    // Repeated headers in LEN, boundary values
    exp_q.push_back(ev(1, 0, 8'h00, 16'h0000, 8'h00, 8'hFF, 2'd1, 16'd5, 16'd4));
    send_byte(8'hAD);
    send_byte(8'hAD);
    send_frame("0000000FF", 8'h0A);

    // Header in terminator slot, then full frame
    exp_q.push_back(ev(0, 1, 8'h00, 16'h0000, 8'h00, 8'hFF, 2'd2, 16'd5, 16'd5));
    send_frame("123456789", 8'hAD);
    exp_q.push_back(ev(1, 0, 8'h0A, 16'hBCDE, 8'hF0, 8'h12, 2'd2, 16'd6, 16'd5));
    send_frame("abcdef012", 8'h0A);

    // Noise while hunting produces nothing
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h0A);
    send_byte(8'h41);
    drain("drain_main");

    // Long stall after the first payload char
`ifdef UART_FRAME_TIMEOUT_EN
    exp_q.push_back(ev(0, 1, 8'h0A, 16'hBCDE, 8'hF0, 8'h12, 2'd3, 16'd6, 16'd6));
`else
    exp_q.push_back(ev(1, 0, 8'h01, 16'h2345, 8'h67, 8'h89, 2'd2, 16'd7, 16'd5));
`endif
    send_byte(8'hAD);
    send_byte(8'h0C);
    send_byte("1");
    repeat (501) @(negedge clk);
    send_str("23456789");
    send_byte(8'h0A);
    drain("drain_stall");

    // Mid-frame reset
    send_byte(8'hAD);
    send_byte(8'h0C);
    send_str("12");
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.push_back(ev(1, 0, 8'h03, 16'h1A2F, 8'h40, 8'h0C, 2'd0, 16'd1, 16'd0));
    send_frame("31A2F400C", 8'h0A);
    drain("drain_post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
